// File: rtl/gsram_pkg.sv
// Shared constants and state encoding for the grid SRAM sequencer.
package gsram_pkg;

    localparam int unsigned ROWS   = 10;
    localparam int unsigned COLS   = 10;
    localparam int unsigned DW     = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned N_ELEM = ROWS * COLS;
    localparam int unsigned CNT_W  = 7;

    localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(COLS - 1);
    localparam logic [CNT_W-1:0]  N_ELEM_C   = CNT_W'(N_ELEM);
    localparam logic [CNT_W-1:0]  LAST_ELEM  = CNT_W'(N_ELEM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/gsram_out_fifo.sv
// Two-entry output FIFO holding a data word plus its last flag.
module gsram_out_fifo
    import gsram_pkg::*;
#(
    parameter int unsigned W = DW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/gsram_seq.sv
// Load/dump sequencer for the 10x10x16 grid SRAM: writes a 100-word stream in
// row-major order, or reads it back as a backpressured stream.
module gsram_seq
    import gsram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              start_dump,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_row,
    output logic [ADDR_W-1:0] sram_col,
    output logic [DW-1:0]     sram_wdata,
    input  logic [DW-1:0]     sram_rdata
);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] w_row_next;
    logic [ADDR_W-1:0] w_col_next;
    logic [ADDR_W-1:0] w_row_inc;
    logic [ADDR_W-1:0] w_col_inc;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  w_issued_next;
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_load_hs;
    logic              w_at_end;
    logic              w_pop;
    logic              w_issue;
    logic              w_dump_end;
    logic [2:0]        w_occ;
    logic [1:0]        w_fifo_count;
    logic [DW:0]       w_fifo_head;

    assign w_at_end  = (r_row == LAST_ROW) && (r_col == LAST_COL);
    assign w_col_inc = (r_col == LAST_COL) ? '0 : r_col + 1'b1;
    assign w_row_inc = (r_col != LAST_COL) ? r_row :
                       (r_row == LAST_ROW) ? '0 : r_row + 1'b1;

    assign w_load_hs = (r_state == ST_LOAD) && in_valid;
    assign w_pop     = out_valid && out_ready;

    // Occupancy credits a same-cycle pop so a free-running consumer sees one word per cycle.
    assign w_occ      = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue    = (r_state == ST_DUMP) && (w_occ < 3'd2) && (r_issued != N_ELEM_C);
    assign w_dump_end = (r_issued == N_ELEM_C) && !r_inflight
                        && (w_fifo_count == {1'b0, w_pop});

    always_comb begin
        w_state_next  = r_state;
        w_row_next    = r_row;
        w_col_next    = r_col;
        w_issued_next = r_issued;
        unique case (r_state)
            ST_IDLE: begin
                if (start_load) begin
                    w_state_next  = ST_LOAD;
                    w_row_next    = '0;
                    w_col_next    = '0;
                    w_issued_next = '0;
                end else if (start_dump) begin
                    w_state_next  = ST_DUMP;
                    w_row_next    = '0;
                    w_col_next    = '0;
                    w_issued_next = '0;
                end
            end
            ST_LOAD: begin
                if (w_load_hs) begin
                    w_row_next = w_row_inc;
                    w_col_next = w_col_inc;
                    if (w_at_end) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DUMP: begin
                if (w_issue) begin
                    w_row_next    = w_row_inc;
                    w_col_next    = w_col_inc;
                    w_issued_next = r_issued + 1'b1;
                end
                if (w_dump_end) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_row           <= '0;
            r_col           <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_row           <= w_row_next;
            r_col           <= w_col_next;
            r_issued        <= w_issued_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_issued == LAST_ELEM);
        end
    end

    // The SRAM returns read data one cycle after the address is presented.
    gsram_out_fifo #(
        .W (DW + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_wdata ({r_inflight_last, sram_rdata}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_count (w_fifo_count)
    );

    always_comb begin
        in_ready   = (r_state == ST_LOAD);
        sram_we    = w_load_hs;
        sram_wdata = in_ready ? in_data : '0;
        sram_row   = ((r_state == ST_LOAD) || (r_state == ST_DUMP)) ? r_row : '0;
        sram_col   = ((r_state == ST_LOAD) || (r_state == ST_DUMP)) ? r_col : '0;
        busy       = (r_state != ST_IDLE);
        done       = (r_state == ST_DONE);
        out_valid  = (w_fifo_count != 2'd0);
        out_data   = w_fifo_head[DW-1:0];
        out_last   = out_valid && w_fifo_head[DW];
    end

endmodule

// File: doc/gsram_seq.md
Name: gsram_seq

Overview:
- Sequencer that sits directly in front of the 10x10x16 grid SRAM and drives its we/row/col/wdata port.
- Load mode: accepts a valid/ready stream of 100 words and writes it into the SRAM in row-major order.
- Dump mode: reads all 100 words back in row-major order and emits them as a backpressured valid/ready stream, with a 2-entry output FIFO absorbing the SRAM's 1-cycle read latency.

Parameters:
ROWS, 10, grid rows
COLS, 10, grid columns
DW, 16, data word width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_load  in  1  begin load; sampled in IDLE only
start_dump  in  1  begin dump; sampled in IDLE only
in_valid  in  1  load data valid
in_data  in  DW  load data
in_ready  out  1  high only in LOAD
out_valid  out  1  dump data valid (FIFO non-empty)
out_data  out  DW  FIFO head
out_ready  in  1  downstream accepts
out_last  out  1  high with element 99 (row 9, col 9)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of load or dump
sram_we  out  1  to SRAM we
sram_row  out  4  to SRAM row
sram_col  out  4  to SRAM col
sram_wdata  out  DW  to SRAM wdata
sram_rdata  in  DW  from SRAM rdata; valid the cycle after a read is sampled

Behaviour:
- Reset, asynchronous, rst_n=0:
  - state=IDLE; row/col counters=0; FIFO emptied; in-flight flag cleared.
  - All outputs 0: in_ready, out_valid, out_data, out_last, busy, done, sram_we, sram_row, sram_col, sram_wdata.
  - SRAM contents are not touched.
- States: IDLE, LOAD, DUMP, DONE.
- IDLE:
  - start_load -> LOAD.
  - Else start_dump -> DUMP. load wins if both are high.
  - Counters cleared on entry to LOAD or DUMP.
- LOAD:
  - in_ready=1.
  - sram_we = in_valid (combinational); sram_wdata = in_data; sram_row/col = counters.
  - The SRAM writes at the edge where in_valid&&in_ready.
  - Counters advance only on that handshake: col++; col==COLS-1 wraps col to 0 and increments row.
  - Handshake at (9,9) -> DONE; counters return to 0.
- DUMP:
  - sram_we=0 throughout.
  - A read is issued (counters on sram_row/col, issue flag set) only when FIFO occupancy + in-flight < 2 and issued count < 100.
  - In-flight flag is set on issue; the cycle after issue, sram_rdata is pushed into the FIFO and the flag clears.
  - Counters advance per issue with the same wrap rule.
  - out_last is tracked per FIFO entry and set for element 99.
  - Pop on out_valid&&out_ready; push and pop may occur in the same cycle.
  - After 100 issued, 0 in flight, FIFO empty -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- Start inputs are ignored while busy.
- sram_row/col never leave 0..9; rows 10-15 must never be driven.
- Latency:
  - start_dump sampled at edge E0; first read sampled by SRAM at E1; FIFO push at E2; out_valid high after E2.
  - Sustained throughput is 1 word/cycle with out_ready=1.
- Backpressure: with out_ready=0 the FIFO fills to 2 and issue stalls. No word is lost or duplicated.
- done rises the cycle after the last load handshake or the last out handshake.
- Reset mid-operation: operation is abandoned and the next start restarts from (0,0). A partial load leaves earlier-written SRAM words intact.

Decomposition:
- Package gsram_pkg: ROWS, COLS, DW, ADDR_W=4, N_ELEM=ROWS*COLS, state enum {IDLE, LOAD, DUMP, DONE}.
- Sub-module gsram_out_fifo: 2-entry, DW+1 bits wide (data plus last), push/pop/count, async active-low reset.
- Row/col counter and FSM stay in gsram_seq.

Test Plan:
- Load with in_valid=1 continuous, in_data=i for i=0..99 -> sram_we high 100 cycles; word i written at row i/10, col i%10; done pulse 1 cycle after handshake 99; in_ready=0 afterward.
- Dump after that load with out_ready=1 -> out_data 0..99 on 100 consecutive cycles from E2; out_last only with 99; done pulse next cycle; sram_we=0 throughout.
- Dump with out_ready toggling 1,0,1,0 plus a 7-cycle stall at element 50 -> sequence 0..99 exact, no loss or duplicate; FIFO count never above 2; sram_row/col never above 9.
- Load with in_valid gaps (pattern 1,0,0,1) -> counters advance only on handshake; readback dump matches the written data.
- start_load and start_dump high together in IDLE -> LOAD entered; start_dump pulsed mid-load -> ignored, busy stays 1.
- rst_n low for 1 cycle during dump after element 37 out -> all outputs 0 immediately, IDLE; new dump emits from 0 again.
